// File: rtl/pipe_hazard_if.sv
// Decode-side hazard bundle: instruction fields in, forward selects and pipeline control out.
// The master modport is the decode stage; the slave modport is the hazard controller.
interface pipe_hazard_if #(
  parameter int REGW = 5,
  parameter int FW   = 2
);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_wreg;
  logic [REGW-1:0] id_rn;
  logic            id_m2reg;
  logic            id_md;
  logic            id_mdread;
  logic            flush;
  logic [FW-1:0]   fwd_a;
  logic [FW-1:0]   fwd_b;
  logic            stall;
  logic            issue;
  logic            md_busy;
  logic [31:0]     stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn,
           id_m2reg, id_md, id_mdread, flush,
    input  fwd_a, fwd_b, stall, issue, md_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn,
           id_m2reg, id_md, id_mdread, flush,
    output fwd_a, fwd_b, stall, issue, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for DEPTH post-decode stages: tracks in-flight destinations,
// picks forward sources for both operands and stalls decode on load-use and busy mul/div.
module pipe_hazard_ctrl #(
  parameter int REGW       = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_CYCLES  = 32,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  pipe_hazard_if.slave  hz
);
  localparam int MDW = $clog2(MD_CYCLES + 1);

  logic [DEPTH:1]  v_q, v_d;
  logic [DEPTH:1]  ld_q, ld_d;
  logic [REGW-1:0] rn_q [1:DEPTH];
  logic [REGW-1:0] rn_d [1:DEPTH];
  logic [MDW-1:0]  mdc_q, mdc_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  logic [FW-1:0]   fwd_a_s, fwd_b_s;
  logic            lu_a_s, lu_b_s;
  logic            lu_s, mdh_s, stall_s, issue_s, md_busy_s;

  // Youngest-match search: scanning oldest to youngest lets the smallest k overwrite.
  always_comb begin
    fwd_a_s = {FW{1'b0}};
    fwd_b_s = {FW{1'b0}};
    lu_a_s  = 1'b0;
    lu_b_s  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hz.id_use_rs && (hz.id_rs != {REGW{1'b0}}) && v_q[k] && (rn_q[k] == hz.id_rs)) begin
        fwd_a_s = FW'(k);
        lu_a_s  = ld_q[k] && (k < LOAD_STAGE);
      end else begin
        fwd_a_s = fwd_a_s;
      end
      if (hz.id_use_rt && (hz.id_rt != {REGW{1'b0}}) && v_q[k] && (rn_q[k] == hz.id_rt)) begin
        fwd_b_s = FW'(k);
        lu_b_s  = ld_q[k] && (k < LOAD_STAGE);
      end else begin
        fwd_b_s = fwd_b_s;
      end
    end
  end

  // Stall/issue decisions; flush squashes every hazard and reset forces everything quiet.
  always_comb begin
    md_busy_s = (mdc_q != {MDW{1'b0}});
    lu_s      = hz.id_valid && !hz.flush && (lu_a_s || lu_b_s);
    mdh_s     = hz.id_valid && !hz.flush && (hz.id_md || hz.id_mdread) && md_busy_s;
    stall_s   = !reset && (lu_s || mdh_s);
    issue_s   = !reset && hz.id_valid && !hz.flush && !stall_s;
  end

  // Next-state: scoreboard shift with a bubble on stall/flush, md countdown, saturating counter.
  always_comb begin
    v_d     = {v_q[DEPTH-1:1], issue_s && hz.id_wreg && (hz.id_rn != {REGW{1'b0}})};
    ld_d    = {ld_q[DEPTH-1:1], hz.id_m2reg};
    rn_d[1] = hz.id_rn;
    for (int k = 2; k <= DEPTH; k++) begin
      rn_d[k] = rn_q[k-1];
    end
    if (issue_s && hz.id_md) begin
      mdc_d = MDW'(MD_CYCLES);
    end else if (md_busy_s) begin
      mdc_d = mdc_q - MDW'(1);
    end else begin
      mdc_d = mdc_q;
    end
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; register numbers and load flags need no reset since v gates them.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= {DEPTH{1'b0}};
      mdc_q       <= {MDW{1'b0}};
      stall_cnt_q <= 32'd0;
    end else begin
      v_q         <= v_d;
      mdc_q       <= mdc_d;
      stall_cnt_q <= stall_cnt_d;
    end
    ld_q <= ld_d;
    for (int k = 1; k <= DEPTH; k++) begin
      rn_q[k] <= rn_d[k];
    end
  end

  // Output drive; forward selects are meaningless without a live decode slot.
  always_comb begin
    if (reset || !hz.id_valid) begin
      hz.fwd_a = {FW{1'b0}};
      hz.fwd_b = {FW{1'b0}};
    end else begin
      hz.fwd_a = fwd_a_s;
      hz.fwd_b = fwd_b_s;
    end
    hz.stall     = stall_s;
    hz.issue     = issue_s;
    hz.md_busy   = md_busy_s;
    hz.stall_cnt = stall_cnt_q;
  end
endmodule
